// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: elastic pipeline-stage register with valid/ready handshake,
// flush-to-bubble and an optional 2-entry skid buffer that keeps the
// downstream stall off the upstream ready path.
module pipe_stage_skid #(
  parameter int                 DATA_W = 96,
  parameter logic [DATA_W-1:0]  BUBBLE = DATA_W'({64'h0, 32'h00000013}),
  parameter int                 SKID   = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_flush,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic [1:0]        o_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   out_q, out_d;
  logic [DATA_W-1:0]   skid_q, skid_d;
  logic                upXfer, dnXfer;

  // Handshake outputs; in skid mode ready comes only from registered state,
  // otherwise a full stage may still accept when downstream drains it.
  always_comb begin
    o_valid = (state_q != EMPTY);
    o_data  = out_q;
    o_count = 2'd0;
    case (state_q)
      ONE:     o_count = 2'd1;
      TWO:     o_count = 2'd2;
      default: o_count = 2'd0;
    endcase
    if (SKID != 0) begin
      o_ready = (state_q != TWO) & ~i_rst;
    end else begin
      o_ready = (i_ready | (state_q == EMPTY)) & ~i_rst;
    end
    upXfer = i_valid & o_ready;
    dnXfer = o_valid & i_ready;
  end

  // Next-state logic; flush voids any same-cycle transfer and empties the stage.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    if (i_flush) begin
      state_d = EMPTY;
      out_d   = BUBBLE;
    end else begin
      case (state_q)
        EMPTY: begin
          if (upXfer) begin
            out_d   = i_data;
            state_d = ONE;
          end
        end
        ONE: begin
          if (upXfer && dnXfer) begin
            out_d = i_data;
          end else if (upXfer) begin
            if (SKID != 0) begin
              skid_d  = i_data;
              state_d = TWO;
            end else begin
              out_d = i_data;
            end
          end else if (dnXfer) begin
            out_d   = BUBBLE;
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (dnXfer) begin
            out_d   = skid_q;
            state_d = ONE;
          end
        end
        default: begin
          state_d = EMPTY;
          out_d   = BUBBLE;
        end
      endcase
    end
  end

  // State and output register; reset drops every held entry.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= EMPTY;
      out_q   <= BUBBLE;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
    end
  end

  // Skid register carries no reset: it is only read while the state says it is valid.
  always_ff @(posedge i_clk) begin
    skid_q <= skid_d;
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: directed checks of both backpressure modes (SKID=1 and
// SKID=0, DATA_W=32) followed by a randomised scoreboard run on each.
module tb_pipe_stage_skid;

  localparam logic [31:0] BUB = 32'h00000013;

  logic        clk;
  logic        rst;
  // SKID=1 instance signals
  logic        f1, v1, r1, or1, ov1;
  logic [31:0] d1, od1;
  logic [1:0]  c1;
  // SKID=0 instance signals
  logic        f0, v0, r0, or0, ov0;
  logic [31:0] d0, od0;
  logic [1:0]  c0;

  int tests;
  int failures;

  logic [31:0] q1[$];
  logic [31:0] q0[$];

  pipe_stage_skid #(.DATA_W(32), .BUBBLE(BUB), .SKID(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_flush(f1), .i_valid(v1), .o_ready(or1),
    .i_data(d1), .o_valid(ov1), .i_ready(r1), .o_data(od1), .o_count(c1)
  );

  pipe_stage_skid #(.DATA_W(32), .BUBBLE(BUB), .SKID(0)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_flush(f0), .i_valid(v0), .o_ready(or0),
    .i_data(d0), .o_valid(ov0), .i_ready(r0), .o_data(od0), .o_count(c0)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic fl1, input logic va1, input logic [31:0] da1,
                               input logic re1, input logic fl0, input logic va0,
                               input logic [31:0] da0, input logic re0);
    f1 = fl1; v1 = va1; d1 = da1; r1 = re1;
    f0 = fl0; v0 = va0; d0 = da0; r0 = re0;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic v, input logic [31:0] d,
                        input logic [1:0] c, input logic r);
    checkOutput({tag, " s1 valid"}, {31'd0, ov1}, {31'd0, v});
    checkOutput({tag, " s1 data"},  od1, d);
    checkOutput({tag, " s1 count"}, {30'd0, c1}, {30'd0, c});
    checkOutput({tag, " s1 ready"}, {31'd0, or1}, {31'd0, r});
  endtask

  task automatic check0(input string tag, input logic v, input logic [31:0] d,
                        input logic [1:0] c, input logic r);
    checkOutput({tag, " s0 valid"}, {31'd0, ov0}, {31'd0, v});
    checkOutput({tag, " s0 data"},  od0, d);
    checkOutput({tag, " s0 count"}, {30'd0, c0}, {30'd0, c});
    checkOutput({tag, " s0 ready"}, {31'd0, or0}, {31'd0, r});
  endtask

  initial begin
    logic up1, dn1, up0, dn0;
    tests = 0;
    failures = 0;

    // Reset
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    check1("reset", 0, BUB, 0, 0);
    check0("reset", 0, BUB, 0, 0);
    rst = 1'b0;
    #1;
    check1("post-reset", 0, BUB, 0, 1);
    check0("post-reset", 0, BUB, 0, 1);

    // Stream with downstream always ready
    applyStimulus(0, 1, 32'h1, 1, 0, 0, 0, 0);
    step();
    check1("stream1", 1, 32'h1, 1, 1);
    applyStimulus(0, 1, 32'h2, 1, 0, 0, 0, 0);
    step();
    check1("stream2", 1, 32'h2, 1, 1);
    applyStimulus(0, 1, 32'h3, 1, 0, 0, 0, 0);
    step();
    check1("stream3", 1, 32'h3, 1, 1);
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 0);
    step();
    check1("stream drain", 0, BUB, 0, 1);

    // Backpressure fills the skid buffer, then drains in order
    applyStimulus(0, 1, 32'hA, 0, 0, 0, 0, 0);
    step();
    check1("bp A", 1, 32'hA, 1, 1);
    applyStimulus(0, 1, 32'hB, 0, 0, 0, 0, 0);
    step();
    check1("bp full", 1, 32'hA, 2, 0);
    applyStimulus(0, 1, 32'hEE, 0, 0, 0, 0, 0);
    step();
    check1("bp hold", 1, 32'hA, 2, 0);
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 0);
    step();
    check1("bp deliver B", 1, 32'hB, 1, 1);
    step();
    check1("bp empty", 0, BUB, 0, 1);

    // Flush from TWO with a concurrent upstream offer
    applyStimulus(0, 1, 32'hD, 0, 0, 0, 0, 0);
    step();
    applyStimulus(0, 1, 32'hE, 0, 0, 0, 0, 0);
    step();
    check1("pre-flush", 1, 32'hD, 2, 0);
    applyStimulus(1, 1, 32'hC, 0, 0, 0, 0, 0);
    step();
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 0);
    check1("flush", 0, BUB, 0, 1);
    step();
    check1("flush no C", 0, BUB, 0, 1);

    // Reset with two entries held
    applyStimulus(0, 1, 32'h5, 0, 0, 0, 0, 0);
    step();
    applyStimulus(0, 1, 32'h6, 0, 0, 0, 0, 0);
    step();
    check1("pre-reset", 1, 32'h5, 2, 0);
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 0);
    rst = 1'b1;
    step();
    check1("mid reset", 0, BUB, 0, 0);
    rst = 1'b0;
    #1;
    check1("reset release", 0, BUB, 0, 1);
    step();
    check1("after reset", 0, BUB, 0, 1);

    // SKID=0: combinational ready from downstream
    applyStimulus(0, 0, 0, 1, 0, 1, 32'h7, 0);
    check0("s0 empty accept", 0, BUB, 0, 1);
    step();
    applyStimulus(0, 0, 0, 1, 0, 1, 32'h8, 0);
    check0("s0 stalled", 1, 32'h7, 1, 0);
    step();
    check0("s0 hold", 1, 32'h7, 1, 0);
    applyStimulus(0, 0, 0, 1, 0, 1, 32'h8, 1);
    check0("s0 comb ready", 1, 32'h7, 1, 1);
    step();
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 1);
    check0("s0 replace", 1, 32'h8, 1, 1);
    step();
    check0("s0 drain", 0, BUB, 0, 1);
    applyStimulus(0, 0, 0, 1, 0, 1, 32'h9, 0);
    step();
    applyStimulus(0, 0, 0, 1, 1, 1, 32'hF, 0);
    step();
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 1);
    check0("s0 flush", 0, BUB, 0, 1);

    // Randomised traffic against a FIFO scoreboard on both instances
    q1.delete();
    q0.delete();
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(0, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 3) != 0),
                    0, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 3) != 0));
      up1 = v1 & or1;
      dn1 = ov1 & r1;
      up0 = v0 & or0;
      dn0 = ov0 & r0;
      if (!ov1) checkOutput("rnd s1 bubble", od1, BUB);
      if (!ov0) checkOutput("rnd s0 bubble", od0, BUB);
      if (dn1) begin
        if (q1.size() == 0) checkOutput("rnd s1 spurious", {31'd0, ov1}, 32'd0);
        else checkOutput("rnd s1 order", od1, q1.pop_front());
      end
      if (dn0) begin
        if (q0.size() == 0) checkOutput("rnd s0 spurious", {31'd0, ov0}, 32'd0);
        else checkOutput("rnd s0 order", od0, q0.pop_front());
      end
      if (up1) q1.push_back(d1);
      if (up0) q0.push_back(d0);
      step();
      checkOutput("rnd s1 count", {30'd0, c1}, q1.size());
      checkOutput("rnd s0 count", {30'd0, c0}, q0.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
